// File: rtl/jtag_scan_chain_pkg.sv
// jtag_pa: shared instruction codes, default IDCODE and chain-select type
// for the JTAG scan-register bank. No ports.
package jtag_pa;
    localparam int IR_W_DEFAULT = 4;
    localparam logic [IR_W_DEFAULT-1:0] IR_BYPASS = '1;
    localparam logic [IR_W_DEFAULT-1:0] IR_IDCODE = 4'h1;
    localparam logic [IR_W_DEFAULT-1:0] IR_USER = 4'h2;
    localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_563D;
    typedef enum logic [1:0] {CHAIN_IR, CHAIN_BYPASS, CHAIN_IDCODE, CHAIN_USER} chain_e;
endpackage

// File: rtl/jtag_captureShiftReg.sv
// jtag_captureShiftReg: W-bit capture/shift stage.
// Ports: i_tclk, i_trst_n (async active-low), capture (parallel load of data),
// shift (one serial step with tdi), q (stage value), so (serial out bit).
module jtag_captureShiftReg #(
    parameter int W = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         i_tclk,
    input  logic         i_trst_n,
    input  logic         capture,
    input  logic         shift,
    input  logic         tdi,
    input  logic [W-1:0] data,
    output logic [W-1:0] q,
    output logic         so
);
    always_ff @(posedge i_tclk or negedge i_trst_n)
        if (!i_trst_n)
            q <= '0;
        else if (capture)
            q <= data;
        else if (shift)
            q <= LSB_FIRST ? {tdi, q[W-1:1]} : {q[W-2:0], tdi};

    assign so = LSB_FIRST ? q[0] : q[W-1];
endmodule

// File: rtl/jtag_scan_chain.sv
// jtag_scan_chain: JTAG IR + BYPASS/IDCODE/USER data registers between the
// TAP decodes and the TDI/TDO pins.
// Ports: i_tclk, i_trst_n (async active-low), i_tdi, o_tdo/o_tdoEn (negedge),
// i_stateIs* TAP state decodes, i_userDr (USER capture value),
// o_userDr/o_userDrUpdate (USER update value and strobe), o_ir (instruction).
module jtag_scan_chain
    import jtag_pa::*;
#(
    parameter int IR_W = 4,
    parameter int DR_W = 8,
    parameter logic [31:0] IDCODE = IDCODE_DEFAULT,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            i_tclk,
    input  logic            i_trst_n,
    input  logic            i_tdi,
    output logic            o_tdo,
    output logic            o_tdoEn,
    input  logic            i_stateIsTestLogicReset,
    input  logic            i_stateIsCaptureDr,
    input  logic            i_stateIsShiftDr,
    input  logic            i_stateIsUpdateDr,
    input  logic            i_stateIsCaptureIr,
    input  logic            i_stateIsShiftIr,
    input  logic            i_stateIsUpdateIr,
    input  logic [DR_W-1:0] i_userDr,
    output logic [DR_W-1:0] o_userDr,
    output logic            o_userDrUpdate,
    output logic [IR_W-1:0] o_ir
);
    localparam logic [IR_W-1:0] CODE_BYPASS = {IR_W{IR_BYPASS[0]}};
    localparam logic [IR_W-1:0] CODE_IDCODE = IR_W'(IR_IDCODE);
    localparam logic [IR_W-1:0] CODE_USER = IR_W'(IR_USER);

    logic tlr, cap_ir, cap_dr, sh_ir, sh_dr, upd_ir, upd_dr, cap_any, sh_any;
    logic bypass_q, ir_so, id_so, user_so, tdo_next;
    logic [IR_W-1:0] ir_q;
    logic [31:0] id_q_unused;
    logic [DR_W-1:0] user_q;
    chain_e sel, active;

    // Resolve overlapping decodes: TLR > capture > shift > update
    assign tlr = i_stateIsTestLogicReset;
    assign cap_ir = !tlr && i_stateIsCaptureIr;
    assign cap_dr = !tlr && i_stateIsCaptureDr;
    assign cap_any = cap_ir || cap_dr;
    assign sh_ir = !tlr && !cap_any && i_stateIsShiftIr;
    assign sh_dr = !tlr && !cap_any && i_stateIsShiftDr;
    assign sh_any = sh_ir || sh_dr;
    assign upd_ir = !tlr && !cap_any && !sh_any && i_stateIsUpdateIr;
    assign upd_dr = !tlr && !cap_any && !sh_any && i_stateIsUpdateDr;

    // DR selection follows the committed instruction, not the IR shift stage
    always_comb begin
        sel = o_ir == CODE_BYPASS ? CHAIN_BYPASS :
              o_ir == CODE_IDCODE ? CHAIN_IDCODE :
              o_ir == CODE_USER   ? CHAIN_USER : CHAIN_BYPASS;
        active = sh_ir ? CHAIN_IR : sel;
        tdo_next = active == CHAIN_IR     ? ir_so :
                   active == CHAIN_IDCODE ? id_so :
                   active == CHAIN_USER   ? user_so : bypass_q;
    end

    jtag_captureShiftReg #(.W(IR_W), .LSB_FIRST(LSB_FIRST)) u_ir (
        .i_tclk(i_tclk), .i_trst_n(i_trst_n), .capture(cap_ir), .shift(sh_ir),
        .tdi(i_tdi), .data(IR_W'(2'b01)), .q(ir_q), .so(ir_so)
    );

    jtag_captureShiftReg #(.W(32), .LSB_FIRST(LSB_FIRST)) u_idcode (
        .i_tclk(i_tclk), .i_trst_n(i_trst_n),
        .capture(cap_dr && sel == CHAIN_IDCODE), .shift(sh_dr && sel == CHAIN_IDCODE),
        .tdi(i_tdi), .data(IDCODE), .q(id_q_unused), .so(id_so)
    );

    jtag_captureShiftReg #(.W(DR_W), .LSB_FIRST(LSB_FIRST)) u_user (
        .i_tclk(i_tclk), .i_trst_n(i_trst_n),
        .capture(cap_dr && sel == CHAIN_USER), .shift(sh_dr && sel == CHAIN_USER),
        .tdi(i_tdi), .data(i_userDr), .q(user_q), .so(user_so)
    );

    always_ff @(posedge i_tclk or negedge i_trst_n)
        if (!i_trst_n)
            bypass_q <= 1'b0;
        else if (cap_dr && sel == CHAIN_BYPASS)
            bypass_q <= 1'b0;
        else if (sh_dr && sel == CHAIN_BYPASS)
            bypass_q <= i_tdi;

    always_ff @(posedge i_tclk or negedge i_trst_n)
        if (!i_trst_n) begin
            o_ir <= CODE_IDCODE;
            o_userDr <= '0;
            o_userDrUpdate <= 1'b0;
        end else begin
            o_userDrUpdate <= upd_dr && sel == CHAIN_USER;
            if (tlr)
                o_ir <= CODE_IDCODE;
            else if (upd_ir)
                o_ir <= ir_q;
            if (upd_dr && sel == CHAIN_USER)
                o_userDr <= user_q;
        end

    // TDO launches on the falling edge so the pin is stable at the next rising edge
    always_ff @(negedge i_tclk or negedge i_trst_n)
        if (!i_trst_n) begin
            o_tdo <= 1'b0;
            o_tdoEn <= 1'b0;
        end else begin
            o_tdoEn <= sh_any;
            if (sh_any)
                o_tdo <= tdo_next;
        end
endmodule

// File: tb/tb_jtag_scan_chain.sv
// tb_jtag_scan_chain: scoreboard bench for jtag_scan_chain in both shift orders.
module tb_jtag_scan_chain;
    localparam int IR_W = 4;
    localparam int DR_W = 8;
    localparam logic [31:0] ID = 32'h1000_563D;
    localparam logic [6:0] S_IDLE = 7'b0000000, S_TLR = 7'b1000000, S_CDR = 7'b0100000,
                           S_SDR = 7'b0010000, S_UDR = 7'b0001000, S_CIR = 7'b0000100,
                           S_SIR = 7'b0000010, S_UIR = 7'b0000001;

    logic tclk = 1'b0, trst_n = 1'b0, tdi_a = 1'b0, tdi_b = 1'b0;
    logic tlr = 0, cdr = 0, sdr = 0, udr = 0, cir = 0, sir = 0, uir = 0;
    logic [DR_W-1:0] user_in = '0;
    logic tdo_a, en_a, upd_a, tdo_b, en_b, upd_b;
    logic [DR_W-1:0] ud_a, ud_b;
    logic [IR_W-1:0] ir_a, ir_b;

    int checks = 0, errors = 0;
    bit qa[$], qb[$], ea[$], eb[$];
    logic [IR_W-1:0] mir = 4'h1;
    logic [DR_W-1:0] ud_exp_a = '0, ud_exp_b = '0;

    always #5 tclk = ~tclk;

    jtag_scan_chain #(.IR_W(IR_W), .DR_W(DR_W), .IDCODE(ID), .LSB_FIRST(1'b1)) dut_a (
        .i_tclk(tclk), .i_trst_n(trst_n), .i_tdi(tdi_a), .o_tdo(tdo_a), .o_tdoEn(en_a),
        .i_stateIsTestLogicReset(tlr), .i_stateIsCaptureDr(cdr), .i_stateIsShiftDr(sdr),
        .i_stateIsUpdateDr(udr), .i_stateIsCaptureIr(cir), .i_stateIsShiftIr(sir),
        .i_stateIsUpdateIr(uir), .i_userDr(user_in), .o_userDr(ud_a),
        .o_userDrUpdate(upd_a), .o_ir(ir_a)
    );

    jtag_scan_chain #(.IR_W(IR_W), .DR_W(DR_W), .IDCODE(ID), .LSB_FIRST(1'b0)) dut_b (
        .i_tclk(tclk), .i_trst_n(trst_n), .i_tdi(tdi_b), .o_tdo(tdo_b), .o_tdoEn(en_b),
        .i_stateIsTestLogicReset(tlr), .i_stateIsCaptureDr(cdr), .i_stateIsShiftDr(sdr),
        .i_stateIsUpdateDr(udr), .i_stateIsCaptureIr(cir), .i_stateIsShiftIr(sir),
        .i_stateIsUpdateIr(uir), .i_userDr(user_in), .o_userDr(ud_b),
        .o_userDrUpdate(upd_b), .o_ir(ir_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_st(input logic [6:0] v);
        {tlr, cdr, sdr, udr, cir, sir, uir} = v;
    endtask

    task automatic step();
        @(posedge tclk);
        #1;
    endtask

    // Register contents seen as a bit queue in shift-out order
    function automatic logic [63:0] reg_a();
        logic [63:0] r = '0;
        for (int i = 0; i < qa.size(); i++) r[i] = qa[i];
        return r;
    endfunction

    function automatic logic [63:0] reg_b();
        logic [63:0] r = '0;
        for (int i = 0; i < qb.size(); i++) r[i] = qb[qb.size() - 1 - i];
        return r;
    endfunction

    task automatic model_capture(input bit ir_path);
        int len;
        logic [63:0] c;
        if (ir_path) begin len = IR_W; c = 64'h1; end
        else if (mir == 4'h1) begin len = 32; c = 64'(ID); end
        else if (mir == 4'h2) begin len = DR_W; c = 64'(user_in); end
        else begin len = 1; c = 64'h0; end
        qa.delete();
        qb.delete();
        for (int i = 0; i < len; i++) qa.push_back(c[i]);
        for (int i = len - 1; i >= 0; i--) qb.push_back(c[i]);
    endtask

    task automatic shift_one(input bit ir_path, input bit a, input bit b, output bit la, output bit lb);
        set_st(ir_path ? S_SIR : S_SDR);
        tdi_a = a;
        tdi_b = b;
        la = qa.pop_front();
        lb = qb.pop_front();
        ea.push_back(la);
        eb.push_back(lb);
        qa.push_back(a);
        qb.push_back(b);
        step();
    endtask

    // va is sent LSB first to dut_a, vb MSB first (of n bits) to dut_b
    task automatic scan(input bit ir_path, input int n, input logic [63:0] va, input logic [63:0] vb, input bit upd);
        bit la = 0, lb = 0;
        bit user;
        logic [63:0] ra, rb;
        set_st(ir_path ? S_CIR : S_CDR);
        step();
        model_capture(ir_path);
        for (int k = 0; k < n; k++) shift_one(ir_path, va[k], vb[n-1-k], la, lb);
        user = !ir_path && mir == 4'h2;
        if (upd) begin
            set_st(ir_path ? S_UIR : S_UDR);
            step();
            ra = reg_a();
            rb = reg_b();
            if (ir_path) begin
                chk("ir_a", 64'(ir_a), ra);
                chk("ir_b", 64'(ir_b), rb);
                mir = ra[IR_W-1:0];
            end else begin
                chk("upd_strobe", {upd_a, upd_b}, user ? 2'b11 : 2'b00);
                if (user) begin
                    ud_exp_a = ra[DR_W-1:0];
                    ud_exp_b = rb[DR_W-1:0];
                end
                chk("userdr_a", 64'(ud_a), 64'(ud_exp_a));
                chk("userdr_b", 64'(ud_b), 64'(ud_exp_b));
            end
        end
        set_st(S_IDLE);
        step();
        chk("upd_after", {upd_a, upd_b}, 2'b00);
        chk("tdoen_idle", {en_a, en_b}, 2'b00);
        if (n > 0) chk("tdo_hold", {tdo_a, tdo_b}, {la, lb});
    endtask

    function automatic int dr_len();
        return mir == 4'h1 ? 32 : mir == 4'h2 ? DR_W : 1;
    endfunction

    initial begin
        forever begin
            @(negedge tclk);
            #1;
            if (en_a || en_b) begin
                if (ea.size() == 0 || eb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tdo_unexpected actual=en %b%b expected=no shift", en_a, en_b);
                end else begin
                    chk("tdoen", {en_a, en_b}, 2'b11);
                    chk("tdo_a", 64'(tdo_a), 64'(ea.pop_front()));
                    chk("tdo_b", 64'(tdo_b), 64'(eb.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit la, lb;
        logic [IR_W-1:0] code;
        int n;
        step();
        step();
        trst_n = 1'b1;
        step();
        chk("rst_ir", {ir_a, ir_b}, {4'h1, 4'h1});
        chk("rst_tdoen", {en_a, en_b}, 2'b00);
        chk("rst_tdo", {tdo_a, tdo_b}, 2'b00);
        chk("rst_userdr", {ud_a, ud_b}, 16'h0);
        chk("rst_upd", {upd_a, upd_b}, 2'b00);

        scan(1, IR_W, 64'hF, 64'hF, 1);
        scan(0, 6, 64'b101101, 64'b101101, 0);

        trst_n = 1'b0;
        step();
        trst_n = 1'b1;
        mir = 4'h1;
        ud_exp_a = '0;
        ud_exp_b = '0;
        scan(0, 32, {$urandom, $urandom}, {$urandom, $urandom}, 1);

        scan(1, IR_W, 64'h2, 64'h2, 1);
        user_in = 8'hA5;
        scan(0, DR_W, 64'h3C, 64'h3C, 1);

        for (int it = 0; it < 24; it++) begin
            code = $urandom_range(0, 3) == 0 ? 4'h1 : $urandom_range(0, 2) == 0 ? 4'hF :
                   $urandom_range(0, 1) == 0 ? 4'h2 : IR_W'($urandom);
            scan(1, IR_W, 64'(code), 64'(code), 1);
            user_in = DR_W'($urandom);
            n = dr_len() + ($urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(1, 3)));
            scan(0, n, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        end

        scan(1, IR_W, 64'h2, 64'h2, 1);
        user_in = DR_W'($urandom);
        set_st(S_CDR);
        step();
        model_capture(0);
        for (int k = 0; k < 3; k++) shift_one(0, 1'($urandom), 1'($urandom), la, lb);
        trst_n = 1'b0;
        set_st(S_IDLE);
        #2;
        chk("midrst_ir", {ir_a, ir_b}, {4'h1, 4'h1});
        chk("midrst_tdoen", {en_a, en_b}, 2'b00);
        chk("midrst_tdo", {tdo_a, tdo_b}, 2'b00);
        chk("midrst_userdr", {ud_a, ud_b}, 16'h0);
        chk("midrst_upd", {upd_a, upd_b}, 2'b00);
        step();
        trst_n = 1'b1;
        mir = 4'h1;
        ud_exp_a = '0;
        ud_exp_b = '0;
        step();
        chk("midrst_upd_after", {upd_a, upd_b}, 2'b00);

        scan(1, IR_W, 64'h2, 64'h2, 1);
        set_st(S_TLR);
        step();
        mir = 4'h1;
        set_st(S_IDLE);
        chk("tlr_ir", {ir_a, ir_b}, {4'h1, 4'h1});
        scan(0, 32, {$urandom, $urandom}, {$urandom, $urandom}, 0);

        step();
        chk("queues_drained", 64'(ea.size() + eb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
